// File: rtl/alu_mdu.sv
// ALU plus iterative RISC-V M multiplier/divider behind a valid/ready request/response handshake.
// Latency: 1 cycle for logic/compare/illegal ops and DIV-class special cases, DATA_WIDTH+1 cycles for MUL/DIV iterations.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then one bubble before the next accept.
module alu_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     DivZero
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef logic [OPCODE_LENGTH-1:0] op_t;

    localparam op_t OP_AND    = op_t'(5'b00000);
    localparam op_t OP_OR     = op_t'(5'b00001);
    localparam op_t OP_ADD    = op_t'(5'b00010);
    localparam op_t OP_SUB    = op_t'(5'b00011);
    localparam op_t OP_XOR    = op_t'(5'b00100);
    localparam op_t OP_SLL    = op_t'(5'b00101);
    localparam op_t OP_SRL    = op_t'(5'b00110);
    localparam op_t OP_SRA    = op_t'(5'b00111);
    localparam op_t OP_EQ     = op_t'(5'b01000);
    localparam op_t OP_NE     = op_t'(5'b01001);
    localparam op_t OP_LT     = op_t'(5'b01010);
    localparam op_t OP_GE     = op_t'(5'b01011);
    localparam op_t OP_LTU    = op_t'(5'b01100);
    localparam op_t OP_GEU    = op_t'(5'b01101);
    localparam op_t OP_MUL    = op_t'(5'b10000);
    localparam op_t OP_MULH   = op_t'(5'b10001);
    localparam op_t OP_MULHSU = op_t'(5'b10010);
    localparam op_t OP_MULHU  = op_t'(5'b10011);
    localparam op_t OP_DIV    = op_t'(5'b10100);
    localparam op_t OP_DIVU   = op_t'(5'b10101);
    localparam op_t OP_REM    = op_t'(5'b10110);
    localparam op_t OP_REMU   = op_t'(5'b10111);

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mul(input op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [2*W-1:0]  acc_q, acc_d;     // product accumulator, or remainder in the low W bits
    logic [2*W-1:0]  mc_q, mc_d;       // shifting multiplicand, or dividend/quotient in the low W bits
    logic [W-1:0]    mp_q, mp_d;       // shifting multiplier, or divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;     // negate product / quotient at completion
    logic            rneg_q, rneg_d;   // negate remainder at completion
    logic [W-1:0]    res_q, res_d;
    logic            dz_q, dz_d;

    logic [SW-1:0]   shamt;
    logic [W-1:0]    alu_res;
    logic            a_sgn, b_sgn, a_neg, b_neg, div_ovf;
    logic [W-1:0]    a_mag, b_mag;

    logic [2*W-1:0]  mul_nx, prod_fin;
    logic [W:0]      rem_sh, div_diff;
    logic            div_ok;
    logic [W-1:0]    rem_nx, quo_nx, quo_fin, rem_fin, busy_res;

    assign shamt = SrcB[SW-1:0];

    // Single-cycle class result, evaluated on the live request operands at accept.
    always_comb begin
        alu_res = '0;
        case (Operation)
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLL:  alu_res = SrcA << shamt;
            OP_SRL:  alu_res = SrcA >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(SrcA) >>> shamt);
            OP_EQ:   alu_res = W'(SrcA == SrcB);
            OP_NE:   alu_res = W'(SrcA != SrcB);
            OP_LT:   alu_res = W'($signed(SrcA) < $signed(SrcB));
            OP_GE:   alu_res = W'($signed(SrcA) >= $signed(SrcB));
            OP_LTU:  alu_res = W'(SrcA < SrcB);
            OP_GEU:  alu_res = W'(SrcA >= SrcB);
            default: alu_res = '0;
        endcase
    end

    // Operand signedness and magnitudes; the iterative engine always works on unsigned magnitudes.
    always_comb begin
        a_sgn   = Operation inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn   = Operation inside {OP_MULH, OP_DIV, OP_REM};
        a_neg   = a_sgn & SrcA[W-1];
        b_neg   = b_sgn & SrcB[W-1];
        a_mag   = a_neg ? -SrcA : SrcA;
        b_mag   = b_neg ? -SrcB : SrcB;
        div_ovf = (Operation inside {OP_DIV, OP_REM}) && (SrcA == MOST_NEG) && (&SrcB);
    end

    // One shift-add step and one restoring-division step, plus sign fix-up of the final values.
    always_comb begin
        mul_nx   = acc_q + (mp_q[0] ? mc_q : '0);
        rem_sh   = {acc_q[W-1:0], mc_q[W-1]};
        div_diff = rem_sh - {1'b0, mp_q};
        div_ok   = ~div_diff[W];
        rem_nx   = div_ok ? div_diff[W-1:0] : rem_sh[W-1:0];
        quo_nx   = {mc_q[W-2:0], div_ok};
        prod_fin = neg_q ? -mul_nx : mul_nx;
        quo_fin  = neg_q ? -quo_nx : quo_nx;
        rem_fin  = rneg_q ? -rem_nx : rem_nx;
        case (op_q)
            OP_MUL:                        busy_res = prod_fin[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  busy_res = prod_fin[2*W-1:W];
            OP_DIV, OP_DIVU:               busy_res = quo_fin;
            default:                       busy_res = rem_fin;
        endcase
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = Operation;
                    if (is_mul(Operation)) begin
                        acc_d   = '0;
                        mc_d    = {{W{1'b0}}, a_mag};
                        mp_d    = b_mag;
                        cnt_d   = '0;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = 1'b0;
                        state_d = BUSY;
                    end else if (is_div(Operation)) begin
                        if (SrcB == '0) begin
                            // Quotient all ones, remainder is the dividend.
                            res_d   = (Operation inside {OP_DIV, OP_DIVU}) ? '1 : SrcA;
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            res_d   = (Operation == OP_DIV) ? SrcA : '0;
                            dz_d    = 1'b0;
                            state_d = DONE;
                        end else begin
                            acc_d   = '0;
                            mc_d    = {{W{1'b0}}, a_mag};
                            mp_d    = b_mag;
                            cnt_d   = '0;
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            state_d = BUSY;
                        end
                    end else begin
                        res_d   = alu_res;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (is_mul(op_q)) begin
                    acc_d = mul_nx;
                    mc_d  = mc_q << 1;
                    mp_d  = mp_q >> 1;
                end else begin
                    acc_d = {{W{1'b0}}, rem_nx};
                    mc_d  = {{W{1'b0}}, quo_nx};
                end
                if (cnt_q == CNT_LAST) begin
                    res_d   = busy_res;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign ALUResult = res_q;
    assign DivZero   = dz_q;

endmodule
